spi_bus_arbiter: RTL

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/rr_picker4.sv | 22 ++
 rtl/spi_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encoding, default sizing and small helpers for the SPI bus arbiter.
// Pure declarations: no latency and no flow-control behaviour of its own.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 64;
    localparam int CNT_W       = 8;

    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/rr_picker4.sv
// Combinational 4-way round-robin pick: search starts at last_id+1 and wraps.
// Zero latency; no flow control, valid is low when no request is pending.
module rr_picker4 (
    input  logic [3:0] req,
    input  logic [1:0] last_id,
    output logic       valid,
    output logic [1:0] id
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        id    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_id + 2'(k)]) begin
                valid = 1'b1;
                id    = last_id + 2'(k);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between 4 requesters: grant -> start +1 cycle, done -> response +1 cycle.
// Requests wait (level-held) until granted; master stall beyond TIMEOUT cycles returns an error response.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   m_start,
    output logic [DATA_W-1:0]      m_tx_data,
    output logic [NREQ-1:0]        m_cs_sel,
    input  logic                   m_done,
    input  logic [DATA_W-1:0]      m_rx_data,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        last_id_q, last_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [1:0]        rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              pick_vld;
    logic [1:0]        pick_id;
    logic              timeout_hit;

    rr_picker4 u_picker (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_vld),
        .id      (pick_id)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (m_done || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= 2'd0;
            last_id_q  <= 2'd3;
            cnt_q      <= '0;
            tx_q       <= '0;
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_id;
                    tx_d    = req_data[pick_id*DATA_W +: DATA_W];
                end
            end
            START: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the final count still counts as success.
                if (m_done) begin
                    rsp_id_d   = owner_q;
                    rsp_data_d = m_rx_data;
                    rsp_err_d  = 1'b0;
                end else if (timeout_hit) begin
                    rsp_id_d   = owner_q;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            RESP:    last_id_d = owner_q;
            default: ;
        endcase
    end

    // Grant is suppressed during reset so no requester sees a phantom accept.
    always_comb begin
        gnt       = (state_q == IDLE && pick_vld && !reset) ? id_to_onehot(pick_id) : '0;
        m_start   = (state_q == START);
        busy      = (state_q != IDLE);
        m_cs_sel  = busy ? id_to_onehot(owner_q) : '0;
        m_tx_data = tx_q;
        rsp_valid = (state_q == RESP);
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
    end

endmodule
